// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: bundles the operation/HI-LO signals of the multiply/divide unit.
//
//   start    : launch the operation selected by op (sampled only in IDLE)
//   op       : 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   rs_data  : multiplicand / dividend
//   rt_data  : multiplier / divisor
//   hi_we    : MTHI strobe
//   lo_we    : MTLO strobe
//   wdata    : MTHI/MTLO data
//   busy     : operation in progress (PC stall)
//   done     : one-cycle completion pulse, HI/LO already updated
//   div_zero : sticky, last divide had a zero divisor
//   hi, lo   : architectural HI/LO registers
//
// master : the datapath/control side driving operations
// slave  : the multiply/divide unit
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, hi_we, lo_we, wdata,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with architectural HI/LO.
//
// Executes MULTU/MULT (radix-2 shift-add) and DIVU/DIV (restoring
// shift-subtract) over WIDTH iterations plus one sign-fix cycle, and
// accepts MTHI/MTLO writes while idle.
//
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : muldiv_unit_if.slave (start/op/operands/MTHI/MTLO in,
//           busy/done/div_zero/hi/lo out)
//
// Parameters:
//   WIDTH : operand and HI/LO width
//   CNT_W : iteration counter width, must be able to hold WIDTH
//
// Build option:
//   MULDIV_FAST_MUL_EN : when defined, MULT/MULTU use one combinational
//   2*WIDTH-bit multiply and complete through FIX on the next edge
//   (busy for one cycle). Divides are unaffected.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;

  // multiply: prod holds {partial product, remaining multiplier bits}
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mcand;

  // divide: rem is the partial remainder, quo shifts dividend out / quotient in
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;

  logic               neg_res;   // product / quotient must be negated
  logic               neg_rem;   // remainder takes dividend's sign
  logic               is_div;
  logic               dz_pend;   // current divide has a zero divisor

  logic               busy_q;
  logic               done_q;
  logic               div_zero_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

  // operand conditioning
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   abs_rs;
  logic [WIDTH-1:0]   abs_rt;

  always_comb begin
    rs_neg = bus.op[0] & bus.rs_data[WIDTH-1];
    rt_neg = bus.op[0] & bus.rt_data[WIDTH-1];
    abs_rs = rs_neg ? -bus.rs_data : bus.rs_data;
    abs_rt = rt_neg ? -bus.rt_data : bus.rt_data;
  end

  // one shift-add multiply step
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] prod_step;

  always_comb begin
    msum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? mcand : '0)};
    prod_step = {msum, prod[WIDTH-1:1]};
  end

  // one restoring divide step; the shifted partial remainder is WIDTH+1
  // bits, but the result always fits WIDTH bits, so the subtraction can
  // be done modulo 2^WIDTH once the full-width compare has decided.
  logic [WIDTH:0]     shifted;
  logic               take;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    take     = (shifted >= {1'b0, dvsr});
    rem_step = take ? (shifted[WIDTH-1:0] - dvsr) : shifted[WIDTH-1:0];
    quo_step = {quo[WIDTH-2:0], take};
  end

  // sign correction applied in FIX
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_res ? -prod : prod;
    quo_fix  = neg_res ? -quo  : quo;
    rem_fix  = neg_rem ? -rem  : rem;
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;

  always_comb begin
    fast_prod = (2*WIDTH)'(abs_rs) * (2*WIDTH)'(abs_rt);
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      prod       <= '0;
      mcand      <= '0;
      rem        <= '0;
      quo        <= '0;
      dvsr       <= '0;
      neg_res    <= 1'b0;
      neg_rem    <= 1'b0;
      is_div     <= 1'b0;
      dz_pend    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            // start wins over a simultaneous MTHI/MTLO
            mcand   <= abs_rs;
            prod    <= {{WIDTH{1'b0}}, abs_rt};
            rem     <= '0;
            quo     <= abs_rs;
            dvsr    <= abs_rt;
            neg_res <= rs_neg ^ rt_neg;
            neg_rem <= rs_neg;
            is_div  <= bus.op[1];
            dz_pend <= bus.op[1] & (bus.rt_data == '0);
            cnt     <= '0;
            busy_q  <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
            if (bus.op[1]) begin
              state <= DIV;
            end else begin
              prod  <= fast_prod;
              state <= FIX;
            end
`else
            state   <= bus.op[1] ? DIV : MUL;
`endif
          end else begin
            if (bus.hi_we) hi_q <= bus.wdata;
            if (bus.lo_we) lo_q <= bus.wdata;
          end
        end

        MUL: begin
          prod <= prod_step;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end

        DIV: begin
          rem <= rem_step;
          quo <= quo_step;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) state <= FIX;
        end

        FIX: begin
          if (is_div) begin
            // with a zero divisor every step subtracts nothing, so rem
            // ends as |rs| and its sign fix restores rs exactly
            hi_q       <= rem_fix;
            lo_q       <= dz_pend ? '1 : quo_fix;
            div_zero_q <= dz_pend;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
